xgmac_rx_to_axis: RTL and testbench
===================================

// Module: xgmac_rx_to_axis
// PURPOSE
// - Receive path of the 10G interface: converts the XGMAC client RX bus (rx_data/rx_data_valid, good/bad frame pulse) into a 64-bit AXI4-Stream master.
// - Whole frames are buffered and committed only on rx_good_frame; bad or overflowed frames are rewound and never appear on m_axis.
// - Sits between the XGMAC core and the rx side of the NetFPGA datapath, companion of the AXIS->XGMAC transmit converter.
// PARAMETERS
// - DEPTH_LOG2  9   log2 of buffer depth in 64-bit words (512 words; must hold >= 1 max frame of 190 words)
// - DATA_W      64  data width; KEEP_W = DATA_W/8
// PORTS
// - clk156         in   1   156.25 MHz core clock, all logic on rising edge
// - reset_n        in   1   asynchronous, active-low reset
// - rx_data        in   64  MAC RX data, byte 0 in [7:0]
// - rx_data_valid  in   8   per-byte valid, contiguous from bit 0; 0 = idle cycle
// - rx_good_frame  in   1   1-cycle pulse: frame ended, FCS ok
// - rx_bad_frame   in   1   1-cycle pulse: frame ended, error
// - m_axis_tdata   out  64  stream data
// - m_axis_tkeep   out  8   byte enables (= stored rx_data_valid)
// - m_axis_tuser   out  1   tied 0 (only good frames forwarded)
// - m_axis_tvalid  out  1   stream valid
// - m_axis_tready  in   1   stream ready
// - m_axis_tlast   out  1   last beat of frame
// - stat_good      out  1   1-cycle pulse per committed frame
// - stat_bad       out  1   1-cycle pulse per rx_bad_frame
// - stat_drop      out  1   1-cycle pulse per good frame discarded by overflow
// BEHAVIOUR
// - Reset (async assert, sync release): all pointers 0, hold/overflow flags 0, m_axis_tvalid/tlast 0, tdata/tkeep 0, stats 0.
// - Write side, one-word hold register (hold_vld, hold_data, hold_keep):
//   - beat (rx_data_valid!=0) with hold_vld=1: write hold to buffer with last=0, load new beat into hold.
//   - beat with hold_vld=0: load into hold only.
//   - status pulse with hold_vld=1: write hold with last=1, clear hold_vld (unless a new beat loads it the same cycle).
//   - status pulse and new beat in same cycle: status applies to the held word; new beat becomes hold of the next frame.
//   - status pulse with hold_vld=0 (empty frame): no write; good -> nothing, bad -> stat_bad only.
//   - good and bad asserted together: treated as bad.
// - Pointers: wr_ptr (speculative), cmt_ptr (committed), rd_ptr; DEPTH_LOG2+1 bits with wrap bit.
//   - full = (wr_ptr - rd_ptr) == 2^DEPTH_LOG2.
// - Commit: on good with ovf=0, cmt_ptr <= wr_ptr after the last-word write (same edge), stat_good=1.
// - Bad: wr_ptr <= cmt_ptr, stat_bad=1.
// - Overflow: a write attempted while full sets ovf; further writes of that frame are suppressed. At the frame's status pulse: wr_ptr <= cmt_ptr, ovf <= 0, stat_drop=1 if good, stat_bad=1 if bad.
// - Read side: output register stage, show-ahead.
//   - Loads when rd_ptr != cmt_ptr and (m_axis_tvalid=0 or m_axis_tready=1).
//   - tdata/tkeep/tlast stable while tvalid & !tready.
//   - Throughput 1 beat/cycle under continuous tready.
// - Latency: status pulse in cycle S -> first beat m_axis_tvalid=1 in cycle S+2 (buffer empty, tready=1).
// - Frame of exactly 2^DEPTH_LOG2 words fits only into an empty buffer; a larger frame always drops.
// - Reset mid-frame: buffered and partial frames discarded; no spurious tvalid after release.
// STRUCTURE
// - Package xgmac_rx_pkg: DATA_W, KEEP_W defaults, buffer word layout {last, keep[7:0], data[63:0]} (73 bits).
// - Sub-module xgmac_rx_buffer_ram: simple dual-port RAM, 1-cycle registered read, no reset on storage.
// - Top holds hold register, pointer/commit logic, overflow flag, output stage.
// TESTING
// - Good frame, 9 beats (8 x keep 0xFF, last keep 0x03), good pulse cycle after last beat, tready=1
//   -> 9 beats out, same data, tkeep[8]=0x03, tlast only on beat 8, stat_good=1 once, first tvalid at S+2.
// - Same frame ended with rx_bad_frame -> no m_axis_tvalid, stat_bad=1, wr_ptr back to cmt_ptr.
// - Back-to-back frames, status pulse coincident with next frame's first beat
//   -> both frames intact, second begins with its own first beat.
// - tready=0, DEPTH_LOG2=4: 12-word frame commits, then 8-word frame -> second overflows, stat_drop=1.
//   Release tready -> only the first frame (12 beats) out.
// - Random tready 50% over 100 random-length frames (8..190 words) -> scoreboard match, tdata/tkeep/tlast stable during stall.
// - reset_n low mid-frame and mid-readout -> outputs 0 immediately.
//   After release, next good frame passes unchanged.

Source files
------------

// File: rtl/xgmac_rx_pkg.sv
// Shared definitions for the XGMAC RX -> AXI4-Stream converter:
// default widths, buffer word layout and frame status decoding.
package xgmac_rx_pkg;

    localparam int DEF_DATA_W = 64;
    localparam int DEF_KEEP_W = DEF_DATA_W / 8;
    localparam int BUF_WORD_W = 1 + DEF_KEEP_W + DEF_DATA_W;

    // Buffer word as stored in the RAM, MSB first.
    typedef struct packed {
        logic                  last;
        logic [DEF_KEEP_W-1:0] keep;
        logic [DEF_DATA_W-1:0] data;
    } buf_word_t;

    typedef enum logic [1:0] {
        STS_NONE,
        STS_GOOD,
        STS_BAD
    } rx_status_e;

    // A frame flagged both good and bad is discarded.
    function automatic rx_status_e decode_status(input logic good, input logic bad);
        if (bad) begin
            return STS_BAD;
        end
        if (good) begin
            return STS_GOOD;
        end
        return STS_NONE;
    endfunction

endpackage

// File: rtl/xgmac_rx_to_axis_if.sv
// AXI4-Stream bus carrying received frames out of the converter.
interface xgmac_rx_to_axis_if #(
    parameter int DATA_W = 64
) ();
    logic [DATA_W-1:0]   tdata;
    logic [DATA_W/8-1:0] tkeep;
    logic                tuser;
    logic                tvalid;
    logic                tready;
    logic                tlast;

    modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
    modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/xgmac_rx_buffer_ram.sv
// Simple dual-port frame buffer: one write port, one read port with a
// registered read; only the read register is reset, not the storage.
module xgmac_rx_buffer_ram #(
    parameter int ADDR_W = 9,
    parameter int WORD_W = 73
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WORD_W-1:0] wr_word,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_word
);

    logic [WORD_W-1:0] mem [0:(1 << ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_word;
        end
    end

    // The read register doubles as the stream output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_word <= '0;
        end else if (rd_en) begin
            rd_word <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/xgmac_rx_to_axis.sv
// XGMAC client RX bus to AXI4-Stream: buffers whole frames, commits them on
// rx_good_frame and rewinds bad or overflowed frames so they never appear.
module xgmac_rx_to_axis
    import xgmac_rx_pkg::*;
#(
    parameter int DEPTH_LOG2 = 9,
    parameter int DATA_W     = DEF_DATA_W
) (
    input  logic                  clk156,
    input  logic                  reset_n,
    input  logic [DATA_W-1:0]     rx_data,
    input  logic [DATA_W/8-1:0]   rx_data_valid,
    input  logic                  rx_good_frame,
    input  logic                  rx_bad_frame,
    xgmac_rx_to_axis_if.master    m_axis,
    output logic                  stat_good,
    output logic                  stat_bad,
    output logic                  stat_drop
);

    localparam int KEEP_W = DATA_W / 8;
    localparam int WORD_W = 1 + KEEP_W + DATA_W;
    localparam int PTR_W  = DEPTH_LOG2 + 1;
    localparam logic [PTR_W-1:0] DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic              hold_vld;
    logic [DATA_W-1:0] hold_data;
    logic [KEEP_W-1:0] hold_keep;
    logic              ovf;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  cmt_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              out_vld;

    rx_status_e        status;
    logic              beat;
    logic              full;
    logic              wr_req;
    logic              ovf_hit;
    logic              wr_en;
    logic              wr_last;
    logic [PTR_W-1:0]  wr_ptr_inc;
    logic              rd_load;
    logic [WORD_W-1:0] rd_word;

    always_comb begin
        status     = decode_status(rx_good_frame, rx_bad_frame);
        beat       = |rx_data_valid;
        full       = (wr_ptr - rd_ptr) == DEPTH;
        // Held word goes to the buffer when a new beat displaces it or a good
        // pulse closes the frame; a bad frame's last word is simply dropped.
        wr_req     = hold_vld && ((status == STS_GOOD) || ((status == STS_NONE) && beat));
        ovf_hit    = ovf || (wr_req && full);
        wr_en      = wr_req && !ovf_hit;
        wr_last    = (status == STS_GOOD);
        wr_ptr_inc = wr_ptr + 1'b1;
        rd_load    = (rd_ptr != cmt_ptr) && (!out_vld || m_axis.tready);
    end

    always_ff @(posedge clk156 or negedge reset_n) begin
        if (!reset_n) begin
            hold_vld  <= 1'b0;
            hold_data <= '0;
            hold_keep <= '0;
            ovf       <= 1'b0;
            wr_ptr    <= '0;
            cmt_ptr   <= '0;
            stat_good <= 1'b0;
            stat_bad  <= 1'b0;
            stat_drop <= 1'b0;
        end else begin
            stat_good <= 1'b0;
            stat_bad  <= 1'b0;
            stat_drop <= 1'b0;

            if (beat) begin
                hold_vld  <= 1'b1;
                hold_data <= rx_data;
                hold_keep <= rx_data_valid;
            end else if (status != STS_NONE) begin
                hold_vld  <= 1'b0;
            end

            case (status)
                STS_NONE: begin
                    if (wr_en) begin
                        wr_ptr <= wr_ptr_inc;
                    end
                    if (wr_req && full) begin
                        ovf <= 1'b1;
                    end
                end
                STS_GOOD: begin
                    ovf <= 1'b0;
                    if (ovf_hit) begin
                        wr_ptr    <= cmt_ptr;
                        stat_drop <= 1'b1;
                    end else if (hold_vld) begin
                        wr_ptr    <= wr_ptr_inc;
                        cmt_ptr   <= wr_ptr_inc;
                        stat_good <= 1'b1;
                    end
                end
                default: begin
                    ovf      <= 1'b0;
                    wr_ptr   <= cmt_ptr;
                    stat_bad <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk156 or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr  <= '0;
            out_vld <= 1'b0;
        end else if (rd_load) begin
            rd_ptr  <= rd_ptr + 1'b1;
            out_vld <= 1'b1;
        end else if (m_axis.tready) begin
            out_vld <= 1'b0;
        end
    end

    xgmac_rx_buffer_ram #(
        .ADDR_W (DEPTH_LOG2),
        .WORD_W (WORD_W)
    ) u_ram (
        .clk     (clk156),
        .rst_n   (reset_n),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr[DEPTH_LOG2-1:0]),
        .wr_word ({wr_last, hold_keep, hold_data}),
        .rd_en   (rd_load),
        .rd_addr (rd_ptr[DEPTH_LOG2-1:0]),
        .rd_word (rd_word)
    );

    assign m_axis.tdata  = rd_word[DATA_W-1:0];
    assign m_axis.tkeep  = rd_word[DATA_W +: KEEP_W];
    assign m_axis.tlast  = rd_word[WORD_W-1];
    assign m_axis.tuser  = 1'b0;
    assign m_axis.tvalid = out_vld;

endmodule

// File: tb/tb_xgmac_rx_to_axis.sv
// Scoreboard bench for xgmac_rx_to_axis: instance 0 uses the default 512-word
// buffer, instance 1 a 16-word buffer for the overflow case.
module tb_xgmac_rx_to_axis;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [63:0] rx_data [2];
    logic [7:0]  rx_vld  [2];
    logic        rx_good [2];
    logic        rx_bad  [2];
    logic        rdy     [2];
    logic [1:0]  st_good;
    logic [1:0]  st_bad;
    logic [1:0]  st_drop;
    int          rdy_mode [2];

    logic [63:0] o_data [2];
    logic [7:0]  o_keep [2];
    logic        o_last [2];
    logic        o_user [2];
    logic        o_vld  [2];

    exp_t        sb [2][$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          cnt_good [2] = '{0, 0};
    int          cnt_bad  [2] = '{0, 0};
    int          cnt_drop [2] = '{0, 0};
    int          exp_good [2] = '{0, 0};
    int          exp_bad  [2] = '{0, 0};
    int          exp_drop [2] = '{0, 0};
    logic        pend_g [2] = '{1'b0, 1'b0};
    logic        pend_b [2] = '{1'b0, 1'b0};
    logic        stall_prev [2] = '{1'b0, 1'b0};
    logic [63:0] stall_data [2];
    logic [7:0]  stall_keep [2];
    logic        stall_last [2];

    xgmac_rx_to_axis_if #(.DATA_W(64)) axis0 ();
    xgmac_rx_to_axis_if #(.DATA_W(64)) axis1 ();

    xgmac_rx_to_axis u_dut (
        .clk156        (clk),
        .reset_n       (reset_n),
        .rx_data       (rx_data[0]),
        .rx_data_valid (rx_vld[0]),
        .rx_good_frame (rx_good[0]),
        .rx_bad_frame  (rx_bad[0]),
        .m_axis        (axis0.master),
        .stat_good     (st_good[0]),
        .stat_bad      (st_bad[0]),
        .stat_drop     (st_drop[0])
    );

    xgmac_rx_to_axis #(.DEPTH_LOG2(4)) u_small (
        .clk156        (clk),
        .reset_n       (reset_n),
        .rx_data       (rx_data[1]),
        .rx_data_valid (rx_vld[1]),
        .rx_good_frame (rx_good[1]),
        .rx_bad_frame  (rx_bad[1]),
        .m_axis        (axis1.master),
        .stat_good     (st_good[1]),
        .stat_bad      (st_bad[1]),
        .stat_drop     (st_drop[1])
    );

    assign axis0.tready = rdy[0];
    assign axis1.tready = rdy[1];
    assign o_data[0] = axis0.tdata;  assign o_data[1] = axis1.tdata;
    assign o_keep[0] = axis0.tkeep;  assign o_keep[1] = axis1.tkeep;
    assign o_last[0] = axis0.tlast;  assign o_last[1] = axis1.tlast;
    assign o_user[0] = axis0.tuser;  assign o_user[1] = axis1.tuser;
    assign o_vld[0]  = axis0.tvalid; assign o_vld[1]  = axis1.tvalid;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // tready: mode 0 low, 1 high, 2 random 50%.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 2; i++) begin
            rdy[i] = (rdy_mode[i] == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode[i] == 1);
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset_n) begin
                stall_prev[i] = 1'b0;
            end else begin
                if (st_good[i]) cnt_good[i]++;
                if (st_bad[i])  cnt_bad[i]++;
                if (st_drop[i]) cnt_drop[i]++;
                if (stall_prev[i]) begin
                    check("stall_vld",  o_vld[i],  1'b1);
                    check("stall_data", o_data[i], stall_data[i]);
                    check("stall_keep", o_keep[i], stall_keep[i]);
                    check("stall_last", o_last[i], stall_last[i]);
                end
                if (o_vld[i] && rdy[i]) begin
                    if (sb[i].size() == 0) begin
                        check("unexpected_beat", 1'b1, 1'b0);
                    end else begin
                        exp_t e;
                        e = sb[i].pop_front();
                        check("tdata", o_data[i], e.data);
                        check("tkeep", o_keep[i], e.keep);
                        check("tlast", o_last[i], e.last);
                        check("tuser", o_user[i], 1'b0);
                    end
                end
                stall_prev[i] = o_vld[i] && !rdy[i];
                stall_data[i] = o_data[i];
                stall_keep[i] = o_keep[i];
                stall_last[i] = o_last[i];
            end
        end
    end

    task automatic drive(input int sel, input logic [63:0] d, input logic [7:0] k,
                         input logic g, input logic b);
        rx_data[sel] = d;
        rx_vld[sel]  = k;
        rx_good[sel] = g;
        rx_bad[sel]  = b;
        @(posedge clk);
        #1;
        rx_vld[sel]  = '0;
        rx_good[sel] = 1'b0;
        rx_bad[sel]  = 1'b0;
    endtask

    // Pending status of the previous frame rides on this frame's first beat.
    task automatic send_frame(input int sel, input int len, input logic bad,
                              input logic deliver, input logic [7:0] last_keep);
        logic [63:0] d;
        logic [7:0]  k;
        for (int w = 0; w < len; w++) begin
            d = {$urandom, $urandom};
            k = (w == len - 1) ? last_keep : 8'hFF;
            if (deliver) sb[sel].push_back('{d, k, (w == len - 1)});
            drive(sel, d, k, (w == 0) ? pend_g[sel] : 1'b0, (w == 0) ? pend_b[sel] : 1'b0);
            if (w == 0) begin
                pend_g[sel] = 1'b0;
                pend_b[sel] = 1'b0;
            end
        end
        pend_g[sel] = !bad;
        pend_b[sel] = bad;
    endtask

    task automatic flush(input int sel);
        drive(sel, '0, '0, pend_g[sel], pend_b[sel]);
        pend_g[sel] = 1'b0;
        pend_b[sel] = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain(input int sel);
        int t;
        t = 0;
        while (sb[sel].size() != 0 && t < 5000) begin
            idle(1);
            t++;
        end
        if (t >= 5000) check("drain_timeout", sb[sel].size(), 0);
        idle(4);
    endtask

    task automatic check_stats(input int sel);
        check("stat_good_cnt", cnt_good[sel], exp_good[sel]);
        check("stat_bad_cnt",  cnt_bad[sel],  exp_bad[sel]);
        check("stat_drop_cnt", cnt_drop[sel], exp_drop[sel]);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s;
        int t;
        int len;
        logic bad;
        for (int i = 0; i < 2; i++) begin
            rx_data[i] = '0;
            rx_vld[i]  = '0;
            rx_good[i] = 1'b0;
            rx_bad[i]  = 1'b0;
            rdy[i]     = 1'b0;
            rdy_mode[i] = 1;
        end
        idle(3);
        check("rst_tvalid", o_vld[0], 1'b0);
        check("rst_tdata",  o_data[0], 64'h0);
        check("rst_tkeep",  o_keep[0], 8'h0);
        check("rst_tlast",  o_last[0], 1'b0);
        check("rst_stats",  {st_good, st_bad, st_drop}, 6'h0);
        reset_n = 1'b1;
        idle(2);

        // 9-beat good frame, pulse one cycle after the last beat; check latency.
        send_frame(0, 9, 1'b0, 1'b1, 8'h03);
        s = cyc;
        flush(0);
        exp_good[0]++;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!o_vld[0] && t < 10);
        check("first_beat_latency", cyc - s, 2);
        wait_drain(0);
        check_stats(0);

        // Same frame ended bad: nothing comes out.
        send_frame(0, 9, 1'b1, 1'b0, 8'h03);
        flush(0);
        exp_bad[0]++;
        idle(10);
        check_stats(0);

        // Empty-frame pulses and good+bad together.
        drive(0, '0, '0, 1'b1, 1'b0);
        drive(0, '0, '0, 1'b0, 1'b1);
        exp_bad[0]++;
        send_frame(0, 6, 1'b1, 1'b0, 8'h7F);
        pend_g[0] = 1'b1;
        flush(0);
        exp_bad[0]++;
        idle(6);
        check_stats(0);

        // Back-to-back frames, status coincident with the next first beat.
        send_frame(0, 20, 1'b0, 1'b1, 8'h1F);
        send_frame(0, 15, 1'b0, 1'b1, 8'hFF);
        send_frame(0, 8,  1'b0, 1'b1, 8'h01);
        flush(0);
        exp_good[0] += 3;
        wait_drain(0);
        check_stats(0);

        // Overflow on the 16-word instance with tready held low.
        rdy_mode[1] = 0;
        idle(2);
        send_frame(1, 12, 1'b0, 1'b1, 8'hFF);
        flush(1);
        exp_good[1]++;
        send_frame(1, 8, 1'b0, 1'b0, 8'h0F);
        flush(1);
        exp_drop[1]++;
        idle(5);
        check_stats(1);
        rdy_mode[1] = 1;
        wait_drain(1);
        check_stats(1);

        // Random frames with random tready; wait for space so nothing drops.
        rdy_mode[0] = 2;
        for (int f = 0; f < 100; f++) begin
            len = $urandom_range(8, 190);
            bad = ($urandom_range(0, 7) == 0);
            if (sb[0].size() + len > 512 || $urandom_range(0, 1) == 1) flush(0);
            t = 0;
            while (sb[0].size() + len > 512 && t < 5000) begin
                idle(1);
                t++;
            end
            if (t >= 5000) check("space_timeout", sb[0].size(), 0);
            send_frame(0, len, bad, !bad, 8'hFF >> $urandom_range(0, 7));
            if (bad) exp_bad[0]++;
            else     exp_good[0]++;
        end
        flush(0);
        wait_drain(0);
        check_stats(0);

        // Reset with a committed frame stalled at the output and a partial frame.
        rdy_mode[0] = 0;
        idle(2);
        send_frame(0, 10, 1'b0, 1'b1, 8'hFF);
        flush(0);
        exp_good[0]++;
        send_frame(0, 5, 1'b0, 1'b0, 8'hFF);
        pend_g[0] = 1'b0;
        idle(3);
        check("pre_reset_tvalid", o_vld[0], 1'b1);
        reset_n = 1'b0;
        #1;
        check("reset_tvalid", o_vld[0], 1'b0);
        check("reset_tdata",  o_data[0], 64'h0);
        check("reset_tkeep",  o_keep[0], 8'h0);
        check("reset_tlast",  o_last[0], 1'b0);
        sb[0].delete();
        idle(3);
        reset_n = 1'b1;
        rdy_mode[0] = 1;
        idle(10);
        check("post_reset_tvalid", o_vld[0], 1'b0);
        send_frame(0, 9, 1'b0, 1'b1, 8'h03);
        flush(0);
        exp_good[0]++;
        wait_drain(0);
        check_stats(0);
        check_stats(1);
        check("sb0_empty", sb[0].size(), 0);
        check("sb1_empty", sb[1].size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
